// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output Ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             br_next;
  logic             last;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  always_comb begin
    d       = a_sh[0] ^ b_sh[0] ^ br;
    br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    last    = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      Diff  <= '0;
      Bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      Ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            a_sh  <= A;
            b_sh  <= B;
            br    <= Bin;
            cnt   <= '0;
            state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= {d, res[WIDTH-1:1]};
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          // The final bit is folded in directly so the result publishes on the DONE entry edge.
          if (last) begin
            state <= DONE;
            Diff  <= {d, res[WIDTH-1:1]};
            Bout  <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            Ovf   <= (a_msb != b_msb) && (d != a_msb);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state == SHIFT);
  assign Done = (state == DONE);

endmodule
